// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_e  : controller FSM states (run, waiting on data memory, halted on timeout)
//   REG_ZERO : architectural zero register; never a real dependency
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StHalt    = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard detector (purely combinational).
// Ports:
//   id_rs, id_rt  : source registers of the instruction in ID
//   id_uses_rt    : ID instruction actually reads rt
//   ex_mem_read   : instruction in EX is a load
//   ex_rt         : destination register of that load
//   load_use      : ID must wait one cycle for the load result
module pipe_hazard_ctrl_hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    output logic       load_use
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_rt == id_rs);
    // rt only counts when the ID instruction reads it (not e.g. an I-type destination).
    assign rt_match = id_uses_rt && (ex_rt == id_rt);
    assign load_use = ex_mem_read && (ex_rt != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: the only source of PC/pipeline-register enables and flushes.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   id_rs/id_rt/id_uses_rt, ex_MemRead/ex_rt : load-use detection inputs
//   mem_branch_taken  : branch resolved taken in MEM
//   dmem_req/dmem_ready : data-memory handshake from MEM
//   pc_en, pc_sel_branch : PC load enable and branch-target select
//   *_en / *_flush    : pipeline register load enables and bubble inserts
//   stall_cnt         : saturating count of cycles with pc_en=0 since reset
//   mem_timeout       : sticky error, data memory waited too long (pipe halted)
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned TO_W        = 8,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_rt,
    input  logic             mem_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             pc_sel_branch,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             mem_timeout
);

    // wait_cnt counts completed wait cycles, so the MEM_TIMEOUT-th wait cycle sees this value.
    localparam logic [TO_W-1:0] WaitLast = TO_W'(MEM_TIMEOUT - 1);

    state_e            state_q;
    logic [TO_W-1:0]   wait_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              mem_timeout_q;

    logic mem_wait;
    logic timeout_hit;
    logic load_use;

    assign mem_wait    = dmem_req && !dmem_ready;
    assign timeout_hit = mem_wait && (wait_cnt_q == WaitLast);

    pipe_hazard_ctrl_hazard_detect u_hazard_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_MemRead),
        .ex_rt       (ex_rt),
        .load_use    (load_use)
    );

    // Output decode. Priority: reset > halt > memory wait > branch flush > load-use > normal.
    always_comb begin
        pc_en         = 1'b1;
        pc_sel_branch = 1'b0;
        ifid_en       = 1'b1;
        idex_en       = 1'b1;
        exmem_en      = 1'b1;
        memwb_en      = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exmem_flush   = 1'b0;
        if (rst) begin
            // Load bubbles everywhere while holding the PC.
            pc_en       = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (state_q == StHalt || mem_wait) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (mem_branch_taken) begin
            // The ID instruction is squashed, so any load-use hazard on it is moot.
            pc_sel_branch = 1'b1;
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
            exmem_flush   = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StRun;
            wait_cnt_q    <= '0;
            stall_cnt_q   <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            if (!pc_en && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            unique case (state_q)
                StHalt: begin
                    state_q <= StHalt;
                end
                default: begin
                    if (timeout_hit) begin
                        state_q       <= StHalt;
                        mem_timeout_q <= 1'b1;
                        wait_cnt_q    <= wait_cnt_q + 1'b1;
                    end else if (mem_wait) begin
                        state_q    <= StMemWait;
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end else begin
                        state_q    <= StRun;
                        wait_cnt_q <= '0;
                    end
                end
            endcase
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int unsigned CNT_W = 4;

    // Control vector layout: {pc_en, pc_sel_branch, ifid_en, idex_en, exmem_en, memwb_en,
    //                         ifid_flush, idex_flush, exmem_flush}
    localparam logic [8:0] CTL_RESET   = 9'b0_0_1111_111;
    localparam logic [8:0] CTL_NORMAL  = 9'b1_0_1111_000;
    localparam logic [8:0] CTL_LOADUSE = 9'b0_0_0111_010;
    localparam logic [8:0] CTL_BRANCH  = 9'b1_1_1111_111;
    localparam logic [8:0] CTL_FREEZE  = 9'b0_0_0000_000;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_MemRead;
    logic [4:0]       ex_rt;
    logic             mem_branch_taken;
    logic             dmem_req;
    logic             dmem_ready;
    logic             pc_en;
    logic             pc_sel_branch;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic [CNT_W-1:0] stall_cnt;
    logic             mem_timeout;

    logic [8:0] ctl;
    assign ctl = {pc_en, pc_sel_branch, ifid_en, idex_en, exmem_en, memwb_en,
                  ifid_flush, idex_flush, exmem_flush};

    int checks = 0;
    int passed = 0;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (4),
        .TO_W        (8),
        .CNT_W       (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_uses_rt       (id_uses_rt),
        .ex_MemRead       (ex_MemRead),
        .ex_rt            (ex_rt),
        .mem_branch_taken (mem_branch_taken),
        .dmem_req         (dmem_req),
        .dmem_ready       (dmem_ready),
        .pc_en            (pc_en),
        .pc_sel_branch    (pc_sel_branch),
        .ifid_en          (ifid_en),
        .idex_en          (idex_en),
        .exmem_en         (exmem_en),
        .memwb_en         (memwb_en),
        .ifid_flush       (ifid_flush),
        .idex_flush       (idex_flush),
        .exmem_flush      (exmem_flush),
        .stall_cnt        (stall_cnt),
        .mem_timeout      (mem_timeout)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs            = 5'd1;
        id_rt            = 5'd2;
        id_uses_rt       = 1'b1;
        ex_MemRead       = 1'b0;
        ex_rt            = 5'd9;
        mem_branch_taken = 1'b0;
        dmem_req         = 1'b0;
        dmem_ready       = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        #1;
        checks++;
        if (ctl !== CTL_RESET) $display("FAIL reset_ctl: got %b want %b", ctl, CTL_RESET);
        else passed++;
        checks++;
        if (stall_cnt !== 4'd0) $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
        else passed++;
        checks++;
        if (mem_timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", mem_timeout);
        else passed++;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (ctl !== CTL_NORMAL) $display("FAIL post_reset_ctl: got %b want %b", ctl, CTL_NORMAL);
        else passed++;
        tick();
        checks++;
        if (stall_cnt !== 4'd0) $display("FAIL post_reset_stall: got %0d want 0", stall_cnt);
        else passed++;
    endtask

    task automatic test_load_use();
        // lw $5 in EX, add with rs=5 in ID
        ex_MemRead = 1'b1;
        ex_rt      = 5'd5;
        id_rs      = 5'd5;
        id_rt      = 5'd3;
        #1;
        checks++;
        if (ctl !== CTL_LOADUSE) $display("FAIL load_use_rs: got %b want %b", ctl, CTL_LOADUSE);
        else passed++;
        tick();
        ex_MemRead = 1'b0;
        #1;
        checks++;
        if (ctl !== CTL_NORMAL) $display("FAIL load_use_clear: got %b want %b", ctl, CTL_NORMAL);
        else passed++;
        checks++;
        if (stall_cnt !== 4'd1) $display("FAIL load_use_stall_cnt: got %0d want 1", stall_cnt);
        else passed++;
        tick();
        // Dependency through rt with id_uses_rt=1
        ex_MemRead = 1'b1;
        ex_rt      = 5'd6;
        id_rs      = 5'd1;
        id_rt      = 5'd6;
        id_uses_rt = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_LOADUSE) $display("FAIL load_use_rt: got %b want %b", ctl, CTL_LOADUSE);
        else passed++;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (stall_cnt !== 4'd2) $display("FAIL load_use_rt_stall_cnt: got %0d want 2", stall_cnt);
        else passed++;
    endtask

    task automatic test_no_stall();
        ex_MemRead = 1'b1;
        ex_rt      = 5'd0;
        id_rs      = 5'd0;
        #1;
        checks++;
        if (ctl !== CTL_NORMAL) $display("FAIL no_stall_r0: got %b want %b", ctl, CTL_NORMAL);
        else passed++;
        tick();
        ex_rt      = 5'd7;
        id_rs      = 5'd2;
        id_rt      = 5'd7;
        id_uses_rt = 1'b0;
        #1;
        checks++;
        if (ctl !== CTL_NORMAL) $display("FAIL no_stall_rt_unused: got %b want %b", ctl, CTL_NORMAL);
        else passed++;
        tick();
        ex_MemRead = 1'b0;
        ex_rt      = 5'd4;
        id_rs      = 5'd4;
        #1;
        checks++;
        if (ctl !== CTL_NORMAL) $display("FAIL no_stall_not_load: got %b want %b", ctl, CTL_NORMAL);
        else passed++;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (stall_cnt !== 4'd2) $display("FAIL no_stall_cnt: got %0d want 2", stall_cnt);
        else passed++;
    endtask

    task automatic test_branch();
        mem_branch_taken = 1'b1;
        ex_MemRead       = 1'b1;
        ex_rt            = 5'd5;
        id_rs            = 5'd5;
        #1;
        checks++;
        if (ctl !== CTL_BRANCH) $display("FAIL branch_over_load_use: got %b want %b", ctl, CTL_BRANCH);
        else passed++;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (stall_cnt !== 4'd2) $display("FAIL branch_stall_cnt: got %0d want 2", stall_cnt);
        else passed++;
    endtask

    // n wait cycles then a ready cycle; optional branch held throughout.
    task automatic run_wait(input int n, input logic br, input logic [8:0] ready_ctl);
        dmem_req         = 1'b1;
        dmem_ready       = 1'b0;
        mem_branch_taken = br;
        for (int i = 0; i < n; i++) begin
            #1;
            checks++;
            if (ctl !== CTL_FREEZE) $display("FAIL mem_wait_ctl[%0d]: got %b want %b", i, ctl, CTL_FREEZE);
            else passed++;
            tick();
        end
        dmem_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== ready_ctl) $display("FAIL mem_ready_ctl: got %b want %b", ctl, ready_ctl);
        else passed++;
        tick();
        idle_inputs();
    endtask

    task automatic test_mem_wait();
        run_wait(3, 1'b0, CTL_NORMAL);
        #1;
        checks++;
        if (stall_cnt !== 4'd5) $display("FAIL mem_wait_stall_cnt: got %0d want 5", stall_cnt);
        else passed++;
        // Wait beats a simultaneous branch; the flush lands on the ready cycle.
        // Three more waits must not time out because the counter restarted.
        run_wait(3, 1'b1, CTL_BRANCH);
        #1;
        checks++;
        if (stall_cnt !== 4'd8) $display("FAIL mem_wait2_stall_cnt: got %0d want 8", stall_cnt);
        else passed++;
        checks++;
        if (mem_timeout !== 1'b0) $display("FAIL mem_wait_no_timeout: got %b want 0", mem_timeout);
        else passed++;
    endtask

    task automatic test_timeout();
        dmem_req   = 1'b1;
        dmem_ready = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (mem_timeout !== 1'b0) $display("FAIL timeout_early: got %b want 0", mem_timeout);
        else passed++;
        tick();
        checks++;
        if (mem_timeout !== 1'b1) $display("FAIL timeout_set: got %b want 1", mem_timeout);
        else passed++;
        checks++;
        if (stall_cnt !== 4'd12) $display("FAIL timeout_stall_cnt: got %0d want 12", stall_cnt);
        else passed++;
        dmem_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_FREEZE) $display("FAIL halt_ready_ctl: got %b want %b", ctl, CTL_FREEZE);
        else passed++;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (ctl !== CTL_FREEZE) $display("FAIL halt_idle_ctl: got %b want %b", ctl, CTL_FREEZE);
        else passed++;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (stall_cnt !== 4'd15) $display("FAIL stall_cnt_saturate: got %0d want 15", stall_cnt);
        else passed++;
        checks++;
        if (mem_timeout !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", mem_timeout);
        else passed++;
    endtask

    task automatic test_recover();
        rst = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_RESET) $display("FAIL recover_rst_ctl: got %b want %b", ctl, CTL_RESET);
        else passed++;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (ctl !== CTL_NORMAL) $display("FAIL recover_ctl: got %b want %b", ctl, CTL_NORMAL);
        else passed++;
        checks++;
        if (mem_timeout !== 1'b0 || stall_cnt !== 4'd0)
            $display("FAIL recover_regs: got timeout=%b cnt=%0d want 0/0", mem_timeout, stall_cnt);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_recover();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
